des_sbox_sequencer: RTL and testbench
=====================================

// Module: des_sbox_sequencer
// PURPOSE
//  Time-multiplexes the DES S-box substitution of one 48-bit expanded-and-keyed word onto a shared lookup port.
//  Sits inside the f-function between key-XOR and P-permutation.
//  Drives a combinational S-box bank (S1..S8, selected by index) LANES lookups per cycle and assembles the 32-bit result.
//  Uses a valid/ready handshake on both sides.
// PARAMETERS
//  LANES  1  S-box lookups per cycle; legal values 1,2,4,8. Localparam STEPS = 8/LANES.
// PORTS
//  i_clk      in   1        clock; all state changes on rising edge
//  i_rst      in   1        reset, asynchronous, active-high
//  i_valid    in   1        input word valid
//  o_ready    out  1        block can accept a word
//  i_data     in   48       expanded ^ subkey; S-box j (0=S1) uses i_data[47-6j -: 6]
//  i_abort    in   1        synchronous abort of the current operation
//  o_lk_sel   out  3*LANES  per lane: S-box index 0..7 (S1..S8); lane k at [3k +: 3]
//  o_lk_data  out  6*LANES  per lane: raw 6-bit S-box input; lane k at [6k +: 6]
//  i_lk_data  in   4*LANES  per lane: 4-bit S-box output, valid in the same cycle
//  o_valid    out  1        result valid
//  i_ready    in   1        consumer accepts the result
//  o_data     out  32       substituted word; S-box j result at o_data[31-4j -: 4]
//  o_busy     out  1        high in RUN or DONE
// BEHAVIOUR
//  Reset (async, i_rst=1):
//   - state=IDLE, step=0, capture reg=0, result reg=0.
//   - Outputs: o_ready=1, o_valid=0, o_busy=0, o_data=0, o_lk_sel=0, o_lk_data=0.
//  FSM states IDLE, RUN, DONE. Outputs decoded from registered state; no combinational input->o_ready path.
//  IDLE:
//   - o_ready=1.
//   - On i_valid&o_ready: capture i_data, step<=0, go RUN.
//   - i_data may change freely after the accept edge.
//  RUN:
//   - o_ready=0.
//   - Lane k presents S-box j = step*LANES+k: o_lk_sel=j, o_lk_data=captured[47-6j -: 6].
//   - At the edge, i_lk_data lane k is written to result[31-4j -: 4]; step<=step+1.
//   - When step==STEPS-1, go DONE.
//  DONE:
//   - o_valid=1; o_data holds the full result, stable until the handshake.
//   - On i_ready: go IDLE; o_ready returns the following cycle (no same-cycle re-accept).
//  Lookup port:
//   - Outside RUN, o_lk_sel=0 and o_lk_data=0.
//   - The bank does the row/column decode; this block never reorders bits.
//  Latency: accept at edge T -> o_valid=1 after edge T+STEPS.
//  Minimum initiation interval: STEPS+2 cycles.
//  o_data:
//   - Cleared to 0 on accept.
//   - Partial nibbles are not observable: o_data is driven 0 unless in DONE.
//  i_abort (any state): next edge -> IDLE, step=0, o_valid=0, result=0.
//   - i_abort overrides a simultaneous accept and a simultaneous i_ready.
//  i_rst mid-RUN or mid-DONE: immediate return to the reset values; the word is discarded.
//  step counter width = clog2(STEPS), minimum 1 bit; it never wraps past STEPS-1.
//  An illegal LANES value is a fatal elaboration error (generate-time check).
// STRUCTURE
//  Shared package des_pkg:
//   - State enum {IDLE, RUN, DONE}.
//   - Constants SBOX_N=8, SBOX_IN_W=6, SBOX_OUT_W=4, EXP_W=48, F_W=32.
//  No internal sub-module.
//  The lookup target des_sbox_bank (sbox1..sbox8 behind a 3-bit select) lives in the parent.
//  Multi-lane parents instantiate one bank per lane.
// TESTING (bench instantiates des_sbox_bank per lane; run LANES=1,2,8)
//  1. i_data=48'h0, i_ready=1 -> o_data=32'hEFA72C4D; o_valid rises exactly STEPS cycles after accept.
//  2. i_data=48'hFFFFFFFFFFFF -> o_data=32'hD9CE3DCB; o_lk_sel walks 0..7 in order, LANES per cycle.
//  3. LANES=1, S5 only: i_data[23:18]=6'b000001, rest 0 -> o_data[15:12]=4'hE.
//     o_lk_sel=4 and o_lk_data=6'b000001 in RUN cycle 5.
//  4. Back-pressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_data stable, o_ready=0.
//     Then i_ready=1 -> IDLE; o_ready=1 the next cycle.
//  5. i_abort pulse in the third RUN cycle -> IDLE next edge, o_valid never asserts.
//     A following accept of 48'h0 yields 32'hEFA72C4D.
//  6. Assert i_rst asynchronously mid-RUN -> all outputs take reset values before the next clock edge.
//     i_valid held high during reset is not accepted.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES f-function constants, sequencer state codes and the S1..S8 tables.
package des_pkg;

   localparam int unsigned SBOX_N     = 8;
   localparam int unsigned SBOX_IN_W  = 6;
   localparam int unsigned SBOX_OUT_W = 4;
   localparam int unsigned EXP_W      = 48;
   localparam int unsigned F_W        = 32;
   localparam int unsigned SEL_W      = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // One 256-bit row-major table per S-box; entry (row*16+col) sits at the MSB end first.
   localparam logic [255:0] SBOX_TBL [SBOX_N] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   // Row = outer bits {b5,b0}, column = inner bits b4..b1.
   function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(input logic [SEL_W-1:0]     sel,
                                                         input logic [SBOX_IN_W-1:0] din);
      logic [5:0]   idx;
      logic [255:0] tbl;
      idx = {din[5], din[0], din[4:1]};
      tbl = SBOX_TBL[sel] << {idx, 2'b00};
      return tbl[255:252];
   endfunction

endpackage

// File: rtl/des_sbox_if.sv
// Word handshake plus shared S-box lookup port of the DES substitution sequencer.
interface des_sbox_if #(parameter int unsigned LANES = 1);
   import des_pkg::*;

   logic                          i_valid;
   logic                          o_ready;
   logic [EXP_W-1:0]              i_data;
   logic                          i_abort;
   logic [SEL_W*LANES-1:0]        o_lk_sel;
   logic [SBOX_IN_W*LANES-1:0]    o_lk_data;
   logic [SBOX_OUT_W*LANES-1:0]   i_lk_data;
   logic                          o_valid;
   logic                          i_ready;
   logic [F_W-1:0]                o_data;
   logic                          o_busy;

   modport slave (
      input  i_valid, i_data, i_abort, i_lk_data, i_ready,
      output o_ready, o_lk_sel, o_lk_data, o_valid, o_data, o_busy
   );

   modport master (
      output i_valid, i_data, i_abort, i_lk_data, i_ready,
      input  o_ready, o_lk_sel, o_lk_data, o_valid, o_data, o_busy
   );
endinterface

// File: rtl/des_sbox_bank.sv
// Combinational S1..S8 bank behind a 3-bit select; the parent owns one per lookup lane.
module des_sbox_bank
   import des_pkg::*;
(
   input  logic [SEL_W-1:0]      sel,
   input  logic [SBOX_IN_W-1:0]  lk_in,
   output logic [SBOX_OUT_W-1:0] lk_out_c
);
   assign lk_out_c = sbox_lookup(sel, lk_in);
endmodule

// File: rtl/des_sbox_sequencer.sv
// Walks the eight DES S-box lookups of one 48-bit word over LANES shared lookup
// lanes per cycle and returns the assembled 32-bit substitution result.
module des_sbox_sequencer
   import des_pkg::*;
#(
   parameter int unsigned LANES = 1
)(
   input  logic       i_clk,
   input  logic       i_rst,
   des_sbox_if.slave  bus
);

   localparam int unsigned STEPS  = SBOX_N / LANES;
   localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
      $fatal(1, "des_sbox_sequencer: LANES must be 1, 2, 4 or 8");
   end

   logic [1:0]                  state_q, state_d;
   logic [STEP_W-1:0]           step_q, step_d;
   logic [EXP_W-1:0]            cap_q, cap_d;
   logic [F_W-1:0]              res_q, res_d;
   logic                        ready_q, ready_d;
   logic                        valid_q, valid_d;
   logic                        busy_q, busy_d;
   logic [F_W-1:0]              data_q, data_d;
   logic [SEL_W*LANES-1:0]      lk_sel_q, lk_sel_d;
   logic [SBOX_IN_W*LANES-1:0]  lk_data_q, lk_data_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         cap_q     <= '0;
         res_q     <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         data_q    <= '0;
         lk_sel_q  <= '0;
         lk_data_q <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         cap_q     <= cap_d;
         res_q     <= res_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         data_q    <= data_d;
         lk_sel_q  <= lk_sel_d;
         lk_data_q <= lk_data_d;
      end
   end

   // Next state, then outputs pre-decoded from the next state so every port is a flop.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cap_d     = cap_q;
      res_d     = res_q;
      lk_sel_d  = '0;
      lk_data_d = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.i_valid) begin
               cap_d   = bus.i_data;
               step_d  = '0;
               res_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int unsigned j = 0; j < SBOX_N; j++) begin
               if (step_q == STEP_W'(j / LANES)) begin
                  res_d[F_W-1-SBOX_OUT_W*j -: SBOX_OUT_W] =
                     bus.i_lk_data[SBOX_OUT_W*(j % LANES) +: SBOX_OUT_W];
               end
            end
            if (step_q == STEP_W'(STEPS - 1)) begin
               step_d  = '0;
               state_d = ST_DONE;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort wins over a same-cycle accept or result handshake.
      if (bus.i_abort) begin
         state_d = ST_IDLE;
         step_d  = '0;
         res_d   = '0;
      end

      if (state_d == ST_RUN) begin
         for (int unsigned j = 0; j < SBOX_N; j++) begin
            if (step_d == STEP_W'(j / LANES)) begin
               lk_sel_d[SEL_W*(j % LANES) +: SEL_W]          = SEL_W'(j);
               lk_data_d[SBOX_IN_W*(j % LANES) +: SBOX_IN_W] =
                  cap_d[EXP_W-1-SBOX_IN_W*j -: SBOX_IN_W];
            end
         end
      end

      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_DONE);
      busy_d  = (state_d != ST_IDLE);
      data_d  = (state_d == ST_DONE) ? res_d : '0;
   end

   assign bus.o_ready   = ready_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_data    = data_q;
   assign bus.o_lk_sel  = lk_sel_q;
   assign bus.o_lk_data = lk_data_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Self-checking bench for des_sbox_sequencer: known answers, random words against a
// table-driven DES S-box model, back-pressure, abort, async reset and initiation interval.
module tb_des_sbox_sequencer;

   parameter int unsigned LANES = 1;
   localparam int unsigned STEPS = 8 / LANES;

   localparam logic [255:0] SB [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;

   logic [3*LANES-1:0] obs_sel [8];
   logic [6*LANES-1:0] obs_dat [8];
   logic [4*LANES-1:0] lk_ret;

   des_sbox_if #(.LANES(LANES)) bus();

   des_sbox_sequencer #(.LANES(LANES)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   for (genvar k = 0; k < LANES; k++) begin : g_bank
      des_sbox_bank u_bank (
         .sel      (bus.o_lk_sel[3*k +: 3]),
         .lk_in    (bus.o_lk_data[6*k +: 6]),
         .lk_out_c (lk_ret[4*k +: 4])
      );
   end
   assign bus.i_lk_data = lk_ret;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference f-function substitution: S-box j eats bits 47-6j..42-6j, emits nibble j.
   function automatic logic [31:0] ref_f(input logic [47:0] x);
      logic [31:0] r;
      logic [5:0]  b;
      logic [3:0]  nib;
      int          row, col, idx;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         b   = 6'(x >> (42 - 6*j));
         row = 2*int'(b[5]) + int'(b[0]);
         col = int'(b[4:1]);
         idx = row*16 + col;
         nib = 4'(SB[j] >> (4*(63 - idx)));
         r   = (r << 4) | 32'(nib);
      end
      return r;
   endfunction

   task automatic drive_idle();
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_abort = 1'b0;
      bus.i_ready = 1'b0;
   endtask

   // Waits (bounded) for o_ready, presents w for one edge, returns at the negedge after acceptance.
   task automatic send_word(input logic [47:0] w, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok          = bus.o_ready;
      bus.i_valid = 1'b1;
      bus.i_data  = w;
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_data  = 48'({$urandom(), $urandom()});
   endtask

   // Counts edges after acceptance until o_valid (bounded), recording the lookup port per RUN cycle.
   task automatic collect(output int lat, output logic [31:0] d);
      lat = 0;
      while (!bus.o_valid && lat < 40) begin
         if (lat < 8) begin
            obs_sel[lat] = bus.o_lk_sel;
            obs_dat[lat] = bus.o_lk_data;
         end
         @(negedge clk);
         lat++;
      end
      d = bus.o_data;
   endtask

   task automatic release_word(input int delay);
      repeat (delay) @(negedge clk);
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: got ready %b valid %b busy %b want 1 0 0",
                  bus.o_ready, bus.o_valid, bus.o_busy);
      end
      n_vec++;
      if (bus.o_data !== 32'h0 || bus.o_lk_sel !== '0 || bus.o_lk_data !== '0) begin
         n_err++;
         $display("FAIL reset_data: got data %h sel %h lk %h want all 0",
                  bus.o_data, bus.o_lk_sel, bus.o_lk_data);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got ready %b busy %b want 1 0", bus.o_ready, bus.o_busy);
      end
   endtask

   task automatic test_known_vectors();
      logic [47:0] kin  [2] = '{48'h0, 48'hFFFF_FFFF_FFFF};
      logic [31:0] kout [2] = '{32'hEFA72C4D, 32'hD9CE3DCB};
      logic [31:0] got;
      int          lat;
      bit          ok;
      bus.i_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         send_word(kin[v], ok);
         collect(lat, got);
         n_vec++;
         if (!ok || lat != int'(STEPS)) begin
            n_err++;
            $display("FAIL known_latency[%0d]: got ready %b latency %0d want 1 %0d", v, ok, lat, STEPS);
         end
         n_vec++;
         if (got !== kout[v]) begin
            n_err++;
            $display("FAIL known_data[%0d]: got %h want %h", v, got, kout[v]);
         end
         for (int c = 0; c < int'(STEPS); c++) begin
            for (int k = 0; k < int'(LANES); k++) begin
               int         j;
               logic [2:0] gs;
               logic [5:0] gd;
               j  = c*int'(LANES) + k;
               gs = 3'(obs_sel[c] >> (3*k));
               gd = 6'(obs_dat[c] >> (6*k));
               n_vec++;
               if (gs !== 3'(j) || gd !== 6'(kin[v] >> (42 - 6*j))) begin
                  n_err++;
                  $display("FAIL known_walk[%0d] c%0d k%0d: got sel %0d lk %h want sel %0d lk %h",
                           v, c, k, gs, gd, j, 6'(kin[v] >> (42 - 6*j)));
               end
            end
         end
         @(negedge clk);
         n_vec++;
         if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 32'h0) begin
            n_err++;
            $display("FAIL known_handshake[%0d]: got ready %b valid %b data %h want 1 0 0",
                     v, bus.o_ready, bus.o_valid, bus.o_data);
         end
      end
      bus.i_ready = 1'b0;
   endtask

   task automatic test_single_sbox();
      logic [47:0] w;
      logic [31:0] got;
      int          lat, c5, k5;
      bit          ok;
      w  = 48'h0000_0004_0000;
      c5 = 4 / int'(LANES);
      k5 = 4 % int'(LANES);
      send_word(w, ok);
      collect(lat, got);
      n_vec++;
      if (got[15:12] !== 4'hE || got !== 32'hEFA7EC4D) begin
         n_err++;
         $display("FAIL s5_only_data: got %h want efa7ec4d", got);
      end
      n_vec++;
      if (3'(obs_sel[c5] >> (3*k5)) !== 3'd4 || 6'(obs_dat[c5] >> (6*k5)) !== 6'b000001) begin
         n_err++;
         $display("FAIL s5_only_lookup: got sel %0d lk %b want 4 000001",
                  3'(obs_sel[c5] >> (3*k5)), 6'(obs_dat[c5] >> (6*k5)));
      end
      release_word(0);
   endtask

   task automatic test_backpressure();
      logic [47:0] w;
      logic [31:0] got, exp;
      int          lat;
      bit          ok;
      w   = 48'({$urandom(), $urandom()});
      exp = ref_f(w);
      send_word(w, ok);
      collect(lat, got);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL bp_data: got %h want %h", got, exp);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (bus.o_valid !== 1'b1 || bus.o_data !== exp || bus.o_ready !== 1'b0 || bus.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got valid %b data %h ready %b busy %b want 1 %h 0 1",
                     i, bus.o_valid, bus.o_data, bus.o_ready, bus.o_busy, exp);
         end
      end
      // A new word offered at the release edge must not be taken in the same cycle.
      bus.i_valid = 1'b1;
      bus.i_data  = 48'hFFFF_FFFF_FFFF;
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      n_vec++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_data !== 32'h0) begin
         n_err++;
         $display("FAIL bp_release: got ready %b valid %b busy %b data %h want 1 0 0 0",
                  bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data);
      end
   endtask

   task automatic test_abort();
      logic [31:0] got;
      int          lat, ab;
      bit          ok, seen;
      ab = (STEPS >= 3) ? 2 : int'(STEPS) - 1;
      send_word(48'({$urandom(), $urandom()}), ok);
      repeat (ab) @(negedge clk);
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      n_vec++;
      if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL abort_run: got ready %b busy %b valid %b want 1 0 0",
                  bus.o_ready, bus.o_busy, bus.o_valid);
      end
      seen = 1'b0;
      repeat (STEPS + 3) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL abort_no_valid: got valid seen %b want 0", seen);
      end
      bus.i_valid = 1'b1;
      bus.i_data  = 48'h1234_5678_9ABC;
      bus.i_abort = 1'b1;
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_abort = 1'b0;
      n_vec++;
      if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_vs_accept: got busy %b ready %b want 0 1", bus.o_busy, bus.o_ready);
      end
      send_word(48'({$urandom(), $urandom()}), ok);
      collect(lat, got);
      bus.i_abort = 1'b1;
      bus.i_ready = 1'b1;
      @(negedge clk);
      bus.i_abort = 1'b0;
      bus.i_ready = 1'b0;
      n_vec++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_data !== 32'h0) begin
         n_err++;
         $display("FAIL abort_done: got valid %b ready %b data %h want 0 1 0",
                  bus.o_valid, bus.o_ready, bus.o_data);
      end
      send_word(48'h0, ok);
      collect(lat, got);
      n_vec++;
      if (lat != int'(STEPS) || got !== 32'hEFA72C4D) begin
         n_err++;
         $display("FAIL abort_recover: got latency %0d data %h want %0d efa72c4d", lat, got, STEPS);
      end
      release_word(1);
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] got;
      int          lat;
      bit          ok;
      send_word(48'hFFFF_FFFF_FFFF, ok);
      bus.i_valid = 1'b1;
      bus.i_data  = 48'h0;
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 ||
          bus.o_data !== 32'h0 || bus.o_lk_sel !== '0 || bus.o_lk_data !== '0) begin
         n_err++;
         $display("FAIL async_reset: got ready %b valid %b busy %b data %h sel %h lk %h want 1 0 0 0 0 0",
                  bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data, bus.o_lk_sel, bus.o_lk_data);
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_no_accept: got busy %b ready %b want 0 1", bus.o_busy, bus.o_ready);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      rst = 1'b0;
      send_word(48'hFFFF_FFFF_FFFF, ok);
      collect(lat, got);
      n_vec++;
      if (got !== 32'hD9CE3DCB) begin
         n_err++;
         $display("FAIL reset_recover: got %h want d9ce3dcb", got);
      end
      release_word(0);
   endtask

   task automatic test_random();
      logic [47:0] w;
      logic [31:0] got, exp;
      int          lat;
      bit          ok;
      for (int v = 0; v < 16; v++) begin
         w   = 48'({$urandom(), $urandom()});
         exp = ref_f(w);
         send_word(w, ok);
         collect(lat, got);
         n_vec++;
         if (!ok || lat != int'(STEPS) || got !== exp) begin
            n_err++;
            $display("FAIL random[%0d] %h: got ready %b latency %0d data %h want 1 %0d %h",
                     v, w, ok, lat, got, STEPS, exp);
         end
         for (int c = 0; c < int'(STEPS); c++) begin
            for (int k = 0; k < int'(LANES); k++) begin
               int         j;
               logic [2:0] gs;
               logic [5:0] gd;
               j  = c*int'(LANES) + k;
               gs = 3'(obs_sel[c] >> (3*k));
               gd = 6'(obs_dat[c] >> (6*k));
               n_vec++;
               if (gs !== 3'(j) || gd !== 6'(w >> (42 - 6*j))) begin
                  n_err++;
                  $display("FAIL random_walk[%0d] c%0d k%0d: got sel %0d lk %h want sel %0d lk %h",
                           v, c, k, gs, gd, j, 6'(w >> (42 - 6*j)));
               end
            end
         end
         release_word(int'($urandom_range(0, 3)));
         n_vec++;
         if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL random_release[%0d]: got ready %b valid %b want 1 0", v, bus.o_ready, bus.o_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [47:0] w;
      logic [31:0] got;
      int          lat, t_prev, t_now;
      bit          ok;
      bus.i_ready = 1'b1;
      t_prev = 0;
      for (int v = 0; v < 4; v++) begin
         w = 48'({$urandom(), $urandom()});
         send_word(w, ok);
         t_now = cyc;
         collect(lat, got);
         n_vec++;
         if (got !== ref_f(w)) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: got %h want %h", v, got, ref_f(w));
         end
         if (v > 0) begin
            n_vec++;
            if (t_now - t_prev != int'(STEPS) + 2) begin
               n_err++;
               $display("FAIL b2b_interval[%0d]: got %0d want %0d", v, t_now - t_prev, STEPS + 2);
            end
         end
         t_prev = t_now;
      end
      @(negedge clk);
      bus.i_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_known_vectors();
      test_single_sbox();
      test_backpressure();
      test_abort();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
